// File: rtl/mem_io.sv
// rtl/mem_io.sv - CPU memory port with RAM, STATUS/OUT/TIMER registers and a byte output FIFO
// Each access runs IDLE -> (WAITST) -> DONE and completes with a one-cycle mem_ack.
module mem_io #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int WAIT       = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_ack,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [3:0]    WAIT_LAST = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
  localparam logic [PW:0]   FULL_CNT  = FIFO_DEPTH[PW:0];
  localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  typedef enum logic [1:0] {IDLE, WAITST, DONE} state_t;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              a_wr;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] timer;
  logic [DATA_W-1:0] rd_next;

  logic [DATA_W-1:0] ram [2**ADDR_W];
  logic [7:0]        fifo [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;

  logic full, empty, pop, push, ram_we, finish, out_blocked;
  logic is_status, is_out, is_timer, is_ram;

  assign is_status = (a_addr == ADDR_W'(0));
  assign is_out    = (a_addr == ADDR_W'(1));
  assign is_timer  = (a_addr == ADDR_W'(2));
  assign is_ram    = (a_addr >= ADDR_W'(4));

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign out_valid = !empty;
  assign out_data  = fifo[rd_ptr];
  assign pop       = out_valid && out_ready;

  // A pop on the same edge frees the slot, so a full FIFO can still take the push.
  assign out_blocked = a_wr && is_out && full && !pop;
  assign finish      = (state == DONE) && !out_blocked;
  assign push        = finish && a_wr && is_out;
  assign ram_we      = finish && a_wr && is_ram;

  always_comb begin
    rd_next = '0;
    if (is_status)     rd_next = DATA_W'({count, full, empty});
    else if (is_timer) rd_next = timer;
    else if (is_ram)   rd_next = ram[a_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      a_wr     <= 1'b0;
      a_addr   <= '0;
      a_data   <= '0;
      mem_ack  <= 1'b0;
      rd_data  <= '0;
    end else begin
      mem_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            a_wr     <= mem_wr;
            a_addr   <= mem_addr;
            a_data   <= wr_data;
            wait_cnt <= '0;
            state    <= (WAIT == 0) ? DONE : WAITST;
          end
        end
        WAITST: begin
          if (wait_cnt == WAIT_LAST) state <= DONE;
          else                       wait_cnt <= wait_cnt + 4'd1;
        end
        DONE: begin
          if (finish) begin
            mem_ack <= 1'b1;
            state   <= IDLE;
            if (!a_wr) rd_data <= rd_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (finish && a_wr && is_timer) begin
      timer <= a_data;
    end else begin
      timer <= timer + DATA_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage arrays are not reset; state is forced to IDLE so no write can land during reset.
  always_ff @(posedge clk) begin
    if (push)   fifo[wr_ptr] <= a_data[7:0];
    if (ram_we) ram[a_addr]  <= a_data;
  end
endmodule
